// File: rtl/button_debounce.sv
// button_debounce: per-button 2-FF synchronizer, debounce filter and edge pulses.
// Each channel is an independent button_debounce_lane instance.
// Optional build macro BTN_RELEASE_PULSE_EN adds the btn_release port (1-cycle
// pulse on a debounced 1->0 transition). When the macro is undefined, that port
// and its logic are absent.

module button_debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int CNT_W           = 21
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
`ifdef BTN_RELEASE_PULSE_EN
  ,output logic rel
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             level_nxt;

   // Filter decision: an agreeing sample restarts the count; a full run of
   // mismatches accepts the new level. cnt stops at CNT_MAX, so it never wraps.
   always_comb begin
      cnt_nxt   = '0;
      level_nxt = level;
      if (sync2 != level) begin
         if (cnt == CNT_MAX) level_nxt = sync2;
         else                cnt_nxt   = cnt + 1'b1;
      end
   end

   // Synchronizer, filter state and registered edge pulses.
   // Pulses are derived from level_nxt so they rise together with the level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
         rel   <= 1'b0;
`endif
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         press <= level_nxt & ~level;
`ifdef BTN_RELEASE_PULSE_EN
         rel   <= ~level_nxt & level;
`endif
      end
   end

endmodule

module button_debounce #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int CNT_W           = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press
`ifdef BTN_RELEASE_PULSE_EN
  ,output logic [N_BTN-1:0] btn_release
`endif
);

   // One fully independent lane per button; there is no cross-channel priority.
   for (genvar i = 0; i < N_BTN; i++) begin : g_lane
      button_debounce_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i])
`ifdef BTN_RELEASE_PULSE_EN
        ,.rel   (btn_release[i])
`endif
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4.
// Edge index 0 is the first clock edge that samples a newly driven btn_raw.
// A held level is expected on btn_level at edge 5.
// Release pulses are checked only when BTN_RELEASE_PULSE_EN is defined.

module tb_button_debounce;

   logic       clk;
   logic       rst;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
`ifdef BTN_RELEASE_PULSE_EN
   logic [3:0] btn_release;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   button_debounce #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press)
`ifdef BTN_RELEASE_PULSE_EN
     ,.btn_release (btn_release)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                      input logic [3:0] rel);
      n_tests++;
      assert (btn_level === lvl) else begin
         n_fail++;
         $error("FAIL %s level: got %h expected %h", tag, btn_level, lvl);
      end
      n_tests++;
      assert (btn_press === prs) else begin
         n_fail++;
         $error("FAIL %s press: got %h expected %h", tag, btn_press, prs);
      end
`ifdef BTN_RELEASE_PULSE_EN
      n_tests++;
      assert (btn_release === rel) else begin
         n_fail++;
         $error("FAIL %s release: got %h expected %h", tag, btn_release, rel);
      end
`else
      if (rel !== rel) n_fail++;
`endif
   endtask

   // Run n edges. The level switches from l0 to l1 at edge 'at', and the
   // press/release pulses are expected only at that edge.
   task automatic run(input string tag, input int n, input int at,
                      input logic [3:0] l0, input logic [3:0] l1,
                      input logic [3:0] prs, input logic [3:0] rel);
      for (int e = 0; e < n; e++) begin
         tick();
         chk($sformatf("%s@%0d", tag, e), (e >= at) ? l1 : l0,
             (e == at) ? prs : 4'h0, (e == at) ? rel : 4'h0);
      end
   endtask

   initial begin
      rst     = 1'b1;
      btn_raw = 4'hF;

      // 1: held in reset with all buttons down, then released.
      run("reset_hold", 3, 99, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      run("reset_exit", 7, 5, 4'h0, 4'hF, 4'hF, 4'h0);
      btn_raw = 4'h0;
      run("all_drop", 7, 5, 4'hF, 4'h0, 4'h0, 4'hF);

      // 2: single button press and release.
      btn_raw = 4'b0010;
      run("b1_press", 7, 5, 4'h0, 4'h2, 4'h2, 4'h0);
      btn_raw = 4'h0;
      run("b1_drop", 7, 5, 4'h2, 4'h0, 4'h0, 4'h2);

      // 3: bounce on button 2, where each raw phase lasts 2 cycles.
      for (int i = 0; i < 12; i++) begin
         btn_raw = {1'b0, ((i / 2) % 2 == 0), 2'b00};
         tick();
         chk($sformatf("bounce@%0d", i), 4'h0, 4'h0, 4'h0);
      end
      btn_raw = 4'b0100;
      run("b2_settle", 7, 5, 4'h0, 4'h4, 4'h4, 4'h0);
      btn_raw = 4'h0;
      run("b2_drop", 7, 5, 4'h4, 4'h0, 4'h0, 4'h4);

      // 4: glitch that is one cycle too short to be accepted.
      for (int i = 0; i < 10; i++) begin
         btn_raw = (i < 3) ? 4'b0001 : 4'b0000;
         tick();
         chk($sformatf("glitch@%0d", i), 4'h0, 4'h0, 4'h0);
      end

      // 5: two buttons pressed simultaneously.
      btn_raw = 4'b1001;
      run("b03_press", 7, 5, 4'h0, 4'h9, 4'h9, 4'h0);
      btn_raw = 4'h0;
      run("b03_drop", 7, 5, 4'h9, 4'h0, 4'h0, 4'h9);

      // 6: reset pulse while the filter is counting.
      btn_raw = 4'b0010;
      run("mid_pre", 3, 99, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b1;
      run("mid_rst", 1, 99, 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      run("mid_post", 7, 5, 4'h0, 4'h2, 4'h2, 4'h0);
      btn_raw = 4'h0;
      run("mid_drop", 7, 5, 4'h2, 4'h0, 4'h0, 4'h2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
